alu_stage: RTL and testbench

//  Registered, parametrised ARM data-processing ALU stage with its own NZCV flag register.

---
 rtl/alu_stage_pkg.sv | 28 ++
 rtl/alu_stage_cond_check.sv | 39 +++
 rtl/alu_stage.sv | 140 ++++++++++++++
 tb/tb_alu_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared encodings for the ALU stage: DP opcodes, ARM condition codes and NZCV bit positions.
package alu_stage_pkg;

    typedef enum logic [3:0] {
        OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3,
        OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7,
        OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB,
        OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF
    } alu_op_e;

    typedef enum logic [3:0] {
        CondEq = 4'h0, CondNe = 4'h1, CondCs = 4'h2, CondCc = 4'h3,
        CondMi = 4'h4, CondPl = 4'h5, CondVs = 4'h6, CondVc = 4'h7,
        CondHi = 4'h8, CondLs = 4'h9, CondGe = 4'hA, CondLt = 4'hB,
        CondGt = 4'hC, CondLe = 4'hD, CondAl = 4'hE, CondNv = 4'hF
    } cond_e;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    // TST/TEQ/CMP/CMN occupy 4'b10xx: no writeback, flags always updated.
    function automatic logic is_test_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_stage_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV value.
module alu_stage_cond_check
    import alu_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FlagN];
    assign z = nzcv[FlagZ];
    assign c = nzcv[FlagC];
    assign v = nzcv[FlagV];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            CondEq: pass = z;
            CondNe: pass = !z;
            CondCs: pass = c;
            CondCc: pass = !c;
            CondMi: pass = n;
            CondPl: pass = !n;
            CondVs: pass = v;
            CondVc: pass = !v;
            CondHi: pass = c & !z;
            CondLs: pass = !c | z;
            CondGe: pass = (n == v);
            CondLt: pass = (n != v);
            CondGt: pass = !z & (n == v);
            CondLe: pass = z | (n != v);
            CondAl: pass = 1'b1;
            CondNv: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_stage.sv
// Registered ARM data-processing ALU stage with NZCV flag register and valid/ready output.
// Optional ADD/SUB saturation and sticky Q flag are enabled by defining ALU_SAT_EN.
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter logic [3:0]  FLAG_RST = 4'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [3:0]       cond,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             shifter_carry,
    input  logic             sat_en,
    input  logic             flags_wr,
    input  logic [3:0]       flags_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             rd_we,
    output logic [3:0]       nzcv,
    output logic             q_flag
);

    logic             out_valid_q, rd_we_q, q_flag_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       nzcv_q;

    logic             accept, pass, is_test, upd_flags;
    logic             is_arith, add_cin, add_ovf, sat_hit;
    logic [WIDTH-1:0] add_x, add_y, logic_res, alu_res;
    logic [WIDTH:0]   sum;
    logic [3:0]       nzcv_new;

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    alu_stage_cond_check u_cond_check (
        .cond (cond),
        .nzcv (nzcv_q),
        .pass (pass)
    );

    // Subtraction is a + ~b + 1, so the adder carry-out is directly NOT borrow.
    always_comb begin
        add_x    = operand_a;
        add_y    = operand_b;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        unique case (opcode)
            OpAdd, OpCmn: add_cin = 1'b0;
            OpAdc:        add_cin = nzcv_q[FlagC];
            OpSub, OpCmp: begin add_y = ~operand_b; add_cin = 1'b1; end
            OpSbc:        begin add_y = ~operand_b; add_cin = nzcv_q[FlagC]; end
            OpRsb:        begin add_x = operand_b; add_y = ~operand_a; add_cin = 1'b1; end
            OpRsc:        begin add_x = operand_b; add_y = ~operand_a; add_cin = nzcv_q[FlagC]; end
            default:      is_arith = 1'b0;
        endcase
    end

    assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) & (sum[WIDTH-1] != add_x[WIDTH-1]);

    always_comb begin
        logic_res = '0;
        case (opcode)
            OpAnd, OpTst: logic_res = operand_a & operand_b;
            OpEor, OpTeq: logic_res = operand_a ^ operand_b;
            OpOrr:        logic_res = operand_a | operand_b;
            OpMov:        logic_res = operand_b;
            OpBic:        logic_res = operand_a & ~operand_b;
            OpMvn:        logic_res = ~operand_b;
            default:      logic_res = '0;
        endcase
    end

`ifdef ALU_SAT_EN
    assign sat_hit = sat_en & add_ovf & ((opcode == OpAdd) | (opcode == OpSub));
`else
    logic unused_sat_en;
    assign unused_sat_en = sat_en;
    assign sat_hit       = 1'b0;
`endif

    // Overflow direction follows the first operand's sign.
    always_comb begin
        alu_res = logic_res;
        if (is_arith) begin
            if (sat_hit) begin
                alu_res = add_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                alu_res = sum[WIDTH-1:0];
            end
        end
    end

    assign is_test   = is_test_op(opcode);
    assign upd_flags = is_test | set_flags;
    assign nzcv_new  = {alu_res[WIDTH-1], alu_res == '0,
                        is_arith ? sum[WIDTH] : shifter_carry,
                        is_arith ? add_ovf : nzcv_q[FlagV]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            rd_we_q     <= 1'b0;
            result_q    <= '0;
            nzcv_q      <= FLAG_RST;
            q_flag_q    <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                rd_we_q     <= pass & !is_test;
                result_q    <= pass ? alu_res : '0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (flags_wr) begin
                nzcv_q <= flags_wdata;
            end else if (accept & pass & upd_flags) begin
                nzcv_q <= nzcv_new;
            end
            if (accept & pass & sat_hit) begin
                q_flag_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd_we     = rd_we_q & out_valid_q;
    assign nzcv      = nzcv_q;
    assign q_flag    = q_flag_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed self-checking bench for alu_stage (WIDTH=32) with hand-computed expectations.
module tb_alu_stage;
    import alu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, set_flags, shifter_carry, sat_en;
    logic        flags_wr, out_valid, out_ready, rd_we, q_flag;
    logic [3:0]  opcode, cond, flags_wdata, nzcv;
    logic [31:0] operand_a, operand_b, result;

    int n_cmp = 0;
    int n_err = 0;

    alu_stage #(.WIDTH(32), .FLAG_RST(4'b0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .cond          (cond),
        .set_flags     (set_flags),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .shifter_carry (shifter_carry),
        .sat_en        (sat_en),
        .flags_wr      (flags_wr),
        .flags_wdata   (flags_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .rd_we         (rd_we),
        .nzcv          (nzcv),
        .q_flag        (q_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op and let it be accepted at the next edge; returns #1 after that edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] cd, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic sc, input logic sat);
        opcode        = op;
        cond          = cd;
        set_flags     = s;
        operand_a     = a;
        operand_b     = b;
        shifter_carry = sc;
        sat_en        = sat;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; cond = CondAl;
        set_flags = 1'b0; operand_a = '0; operand_b = '0; shifter_carry = 1'b0;
        sat_en = 1'b0; flags_wr = 1'b0; flags_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_rd_we", rd_we, 0);
        check_eq("rst_nzcv", nzcv, 4'b0000);
        check_eq("rst_q_flag", q_flag, 0);
        check_eq("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;

        // Signed overflow on ADD
        issue(OpAdd, CondAl, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        check_eq("add_ovf_result", result, 32'h8000_0000);
        check_eq("add_ovf_rd_we", rd_we, 1);
        check_eq("add_ovf_nzcv", nzcv, 4'b1001);

        // Zero result, then a condition-failed op
        issue(OpSub, CondAl, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
        check_eq("sub_zero_result", result, 0);
        check_eq("sub_zero_nzcv", nzcv, 4'b0110);
        issue(OpAdc, CondNe, 1'b1, 32'd2, 32'd3, 1'b0, 1'b0);
        check_eq("ne_fail_valid", out_valid, 1);
        check_eq("ne_fail_rd_we", rd_we, 0);
        check_eq("ne_fail_result", result, 0);
        check_eq("ne_fail_nzcv", nzcv, 4'b0110);

        // Carry produced and consumed back-to-back
        issue(OpAdd, CondAl, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        check_eq("add_carry_nzcv", nzcv, 4'b0110);
        issue(OpAdc, CondAl, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("adc_b2b_result", result, 32'h1);
        check_eq("adc_b2b_nzcv", nzcv, 4'b0110);

        // Logical and compare ops
        issue(OpMvn, CondAl, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("mvn_result", result, 32'hFFFF_FFFF);
        check_eq("mvn_nzcv", nzcv, 4'b1010);
        issue(OpCmp, CondAl, 1'b0, 32'd3, 32'd5, 1'b0, 1'b0);
        check_eq("cmp_rd_we", rd_we, 0);
        check_eq("cmp_nzcv", nzcv, 4'b1000);
        issue(OpRsb, CondAl, 1'b1, 32'd1, 32'd3, 1'b0, 1'b0);
        check_eq("rsb_result", result, 32'd2);
        check_eq("rsb_nzcv", nzcv, 4'b0010);
        issue(OpBic, CondAl, 1'b0, 32'hFF, 32'h0F, 1'b0, 1'b0);
        check_eq("bic_result", result, 32'hF0);
        check_eq("bic_rd_we", rd_we, 1);
        issue(OpMov, CondNv, 1'b1, 32'h0, 32'd5, 1'b0, 1'b0);
        check_eq("nv_rd_we", rd_we, 0);
        check_eq("nv_nzcv", nzcv, 4'b0010);

        // Backpressure: one op in the output register, the next held at the input
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("drain_valid", out_valid, 0);
        out_ready = 1'b0;
        issue(OpMov, CondAl, 1'b0, 32'h0, 32'h11, 1'b0, 1'b0);
        check_eq("stall_first_result", result, 32'h11);
        operand_b = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_hold_result", result, 32'h11);
            check_eq("stall_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("stall_second_result", result, 32'h22);
        check_eq("stall_second_valid", out_valid, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stall_empty_valid", out_valid, 0);

        // Direct flag load, alone and colliding with a CMP
        flags_wr = 1'b1;
        flags_wdata = 4'b1111;
        @(posedge clk);
        #1;
        check_eq("flags_wr_idle", nzcv, 4'b1111);
        flags_wdata = 4'b0010;
        issue(OpCmp, CondAl, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        check_eq("flags_wr_wins", nzcv, 4'b0010);
        flags_wr = 1'b0;

        // Reset while ops are flowing
        issue(OpMov, CondAl, 1'b0, 32'h0, 32'h7, 1'b0, 1'b0);
        check_eq("pre_reset_result", result, 32'h7);
        reset_n = 1'b0;
        issue(OpMov, CondAl, 1'b1, 32'h0, 32'h9, 1'b0, 1'b0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_nzcv", nzcv, 4'b0000);
        reset_n = 1'b1;

        // Saturating add
        issue(OpAdd, CondAl, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
`ifdef ALU_SAT_EN
        check_eq("sat_result", result, 32'h7FFF_FFFF);
        check_eq("sat_q_flag", q_flag, 1);
`else
        check_eq("sat_result", result, 32'h8000_0000);
        check_eq("sat_q_flag", q_flag, 0);
`endif
        check_eq("sat_v_flag", nzcv[0], 1);
        issue(OpMov, CondAl, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef ALU_SAT_EN
        check_eq("sat_q_sticky", q_flag, 1);
`else
        check_eq("sat_q_sticky", q_flag, 0);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
